mem_port_arbiter: RTL and testbench

Sequencer and arbiter in front of the unified instruction/data `MEMORY` array. It shares that single-ported storage between the instruction-fetch requester and the data (load/store) requester. Arbitration is round-robin by default. Every transaction runs as a registered, fixed-latency strobe sequence with a one-cycle acknowledge. It replaces the ad-hoc alternation between the fetch and data paths, so neither side can starve or collide.

---
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer sharing one single-ported memory between instruction fetch and data access.
// Optional macro ARB_DATA_PRIORITY_EN: fixed data priority on ties instead of round-robin.
module mem_port_arbiter #(
  parameter int WORD_SIZE   = 32,
  parameter int IADDR_WIDTH = 20
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   if_req,
  input  logic [IADDR_WIDTH-1:0] if_addr,
  output logic                   if_ack,
  output logic [WORD_SIZE-1:0]   if_rdata,
  input  logic                   dm_req,
  input  logic                   dm_we,
  input  logic [WORD_SIZE-1:0]   dm_addr,
  input  logic [WORD_SIZE-1:0]   dm_wdata,
  output logic                   dm_ack,
  output logic [WORD_SIZE-1:0]   dm_rdata,
  output logic [IADDR_WIDTH-1:0] mem_i_address,
  output logic                   mem_i_enable,
  output logic [WORD_SIZE-1:0]   mem_address,
  output logic [WORD_SIZE-1:0]   mem_data_in,
  output logic                   mem_load,
  output logic                   mem_store,
  input  logic [WORD_SIZE-1:0]   mem_data_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_ACK   = 2'd3;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_DM = 1'b1;

  logic [1:0] state;
  logic       last_grant;
  logic       cur_dm;
  logic       cur_we;
  logic       grant_dm;

  // Arbitration decision, only consumed in IDLE
  always_comb begin
    grant_dm = 1'b0;
    if (dm_req && !if_req) begin
      grant_dm = 1'b1;
    end else if (dm_req && if_req) begin
`ifdef ARB_DATA_PRIORITY_EN
      grant_dm = 1'b1;
`else
      grant_dm = (last_grant == GNT_IF);
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_IDLE;
      last_grant    <= GNT_DM;
      cur_dm        <= 1'b0;
      cur_we        <= 1'b0;
      if_ack        <= 1'b0;
      dm_ack        <= 1'b0;
      if_rdata      <= '0;
      dm_rdata      <= '0;
      mem_i_address <= '0;
      mem_i_enable  <= 1'b0;
      mem_address   <= '0;
      mem_data_in   <= '0;
      mem_load      <= 1'b0;
      mem_store     <= 1'b0;
    end else begin
      // Strobes and acks are single-cycle pulses; addresses and data hold
      if_ack       <= 1'b0;
      dm_ack       <= 1'b0;
      mem_i_enable <= 1'b0;
      mem_load     <= 1'b0;
      mem_store    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (if_req || dm_req) begin
            state  <= S_ISSUE;
            cur_dm <= grant_dm;
            if (grant_dm) begin
              cur_we      <= dm_we;
              mem_address <= dm_addr;
              if (dm_we) begin
                mem_data_in <= dm_wdata;
                mem_store   <= 1'b1;
              end else begin
                mem_load <= 1'b1;
              end
            end else begin
              cur_we        <= 1'b0;
              mem_i_address <= if_addr;
              mem_i_enable  <= 1'b1;
              mem_load      <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          // Stores commit at the end of ISSUE, so they skip the read-data cycle
          if (cur_we) begin
            dm_ack <= 1'b1;
            state  <= S_ACK;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cur_dm) begin
            dm_rdata <= mem_data_out;
            dm_ack   <= 1'b1;
          end else begin
            if_rdata <= mem_data_out;
            if_ack   <= 1'b1;
          end
          state <= S_ACK;
        end
        default: begin
          last_grant <= cur_dm;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter with a registered-read memory model.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req;
  logic [19:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic [19:0] mem_i_address;
  logic        mem_i_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic        mem_load;
  logic        mem_store;
  logic [31:0] mem_data_out;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.WORD_SIZE(32), .IADDR_WIDTH(20)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_i_address(mem_i_address), .mem_i_enable(mem_i_enable),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_load(mem_load), .mem_store(mem_store), .mem_data_out(mem_data_out)
  );

  always #5 clock = ~clock;

  // Unified memory, not reset, read data registered
  logic [31:0] mem [256];
  always @(posedge clock) begin
    if (mem_store) mem[mem_address[7:0]] <= mem_data_in;
    if (mem_load) mem_data_out <= mem_i_enable ? mem[mem_i_address[7:0]] : mem[mem_address[7:0]];
  end

  typedef struct {
    string       name;
    logic        is_dm;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " acks/strobes"}, {27'd0, if_ack, dm_ack, mem_load, mem_store, mem_i_enable}, 32'd0);
    check({tag, " if_rdata"}, if_rdata, 32'd0);
    check({tag, " dm_rdata"}, dm_rdata, 32'd0);
    check({tag, " mem_address"}, mem_address, 32'd0);
    check({tag, " mem_i_address"}, {12'd0, mem_i_address}, 32'd0);
    check({tag, " mem_data_in"}, mem_data_in, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1; if_req = 1'b0; dm_req = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic run_txn(input vec_t v);
    int   lat;
    logic got_dm;
    lat = 0; got_dm = 1'b0;
    @(posedge clock); #1;
    if (v.is_dm) begin
      dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr[19:0];
    end
    for (int c = 1; c <= 10 && lat == 0; c++) begin
      @(posedge clock); #1;
      if (c == 1) begin
        check({v.name, " strobes c1"}, {29'd0, mem_load, mem_store, mem_i_enable},
              {29'd0, !(v.is_dm && v.we), v.is_dm && v.we, !v.is_dm});
        if (v.is_dm) check({v.name, " mem_address"}, mem_address, v.addr);
        else         check({v.name, " mem_i_address"}, {12'd0, mem_i_address}, {12'd0, v.addr[19:0]});
      end
      if (c == 2) check({v.name, " strobes c2"}, {30'd0, mem_load, mem_store}, 32'd0);
      if (if_ack || dm_ack) begin
        lat = c; got_dm = dm_ack;
      end
    end
    if_req = 1'b0; dm_req = 1'b0;
    check({v.name, " latency"}, lat, v.exp_lat);
    check({v.name, " ack side"}, {31'd0, got_dm}, {31'd0, v.is_dm});
    if (!v.we) check({v.name, " rdata"}, v.is_dm ? dm_rdata : if_rdata, v.exp_rdata);
    @(posedge clock); #1;
    check({v.name, " ack one cycle"}, {30'd0, if_ack, dm_ack}, 32'd0);
  endtask

  initial begin
    int   n;
    int   ack_cyc [4];
    logic ack_dm  [4];
    int   viol, issued, acked, busy;
    logic [3:0] exp_sides;

    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[0] = 32'h27E00001;
    mem[5] = 32'h0A5A5A5A;
    if_addr = '0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;

    vecs[0] = '{"fetch0",   1'b0, 1'b0, 32'd0,   32'd0,          32'h27E00001, 3};
    vecs[1] = '{"store100", 1'b1, 1'b1, 32'd100, 32'hDEADBEEF,   32'd0,        2};
    vecs[2] = '{"load100",  1'b1, 1'b0, 32'd100, 32'd0,          32'hDEADBEEF, 3};
    vecs[3] = '{"fetch5",   1'b0, 1'b0, 32'd5,   32'd0,          32'h0A5A5A5A, 3};
    vecs[4] = '{"store7",   1'b1, 1'b1, 32'd7,   32'hCAFEF00D,   32'd0,        2};
    vecs[5] = '{"fetch7",   1'b0, 1'b0, 32'd7,   32'd0,          32'hCAFEF00D, 3};
    vecs[6] = '{"load5",    1'b1, 1'b0, 32'd5,   32'd0,          32'h0A5A5A5A, 3};

    do_reset();
    check_all_zero("reset");

    for (int i = 0; i < 7; i++) run_txn(vecs[i]);

    // Both requesters held high: grant order and spacing
    do_reset();
    @(posedge clock); #1;
    if_req = 1'b1; if_addr = 20'd0; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'd100;
    n = 0;
    for (int i = 0; i < 4; i++) begin ack_cyc[i] = 0; ack_dm[i] = 1'b0; end
    for (int c = 1; c <= 16; c++) begin
      @(posedge clock); #1;
      if (if_ack && dm_ack) check("tie double ack", 32'd1, 32'd0);
      if (if_ack || dm_ack) begin
        if (n < 4) begin ack_cyc[n] = c; ack_dm[n] = dm_ack; end
        n++;
      end
    end
    if_req = 1'b0; dm_req = 1'b0;
`ifdef ARB_DATA_PRIORITY_EN
    exp_sides = 4'b1111;
`else
    exp_sides = 4'b1010;
`endif
    check("tie ack count", n, 4);
    check("tie sides", {28'd0, ack_dm[3], ack_dm[2], ack_dm[1], ack_dm[0]}, {28'd0, exp_sides});
    check("tie ack0 cycle", ack_cyc[0], 3);
    check("tie ack3 cycle", ack_cyc[3], 15);
    repeat (6) @(posedge clock);

    // Reset during the WAIT cycle of a load
    #1 dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'd100;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1; dm_req = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    check_all_zero("rst-wait");
    n = 0;
    repeat (4) begin
      @(posedge clock); #1;
      if (dm_ack || if_ack) n++;
    end
    check("rst-wait no ack", n, 0);
    run_txn(vecs[2]);

    // Random mixed traffic
    viol = 0; issued = 0; acked = 0;
    for (int c = 0; c < 1000; c++) begin
      @(posedge clock); #1;
      if (mem_load && mem_store) viol++;
      if (mem_i_enable && !mem_load) viol++;
      if (if_ack && dm_ack) viol++;
      if (if_ack) begin acked++; if_req = 1'b0; end
      else if (!if_req && $urandom_range(0, 1) == 1) begin
        if_req = 1'b1; if_addr = 20'($urandom_range(0, 255)); issued++;
      end
      if (dm_ack) begin acked++; dm_req = 1'b0; end
      else if (!dm_req && $urandom_range(0, 1) == 1) begin
        dm_req = 1'b1; dm_we = 1'($urandom_range(0, 1));
        dm_addr = 32'($urandom_range(200, 215)); dm_wdata = $urandom; issued++;
      end
    end
    busy = 0;
    while ((if_req || dm_req) && busy < 40) begin
      @(posedge clock); #1;
      if (mem_load && mem_store) viol++;
      if (if_ack) begin acked++; if_req = 1'b0; end
      if (dm_ack) begin acked++; dm_req = 1'b0; end
      busy++;
    end
    check("random exclusion violations", viol, 0);
    check("random all requests acked", acked, issued);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
